rf_wb_queue: RTL
================

Name: rf_wb_queue

Overview:
- Write-back buffer directly upstream of the register file write port.
- Accepts register-write requests from the execute/load stages over a valid/ready handshake and buffers them in a small FIFO.
- Drains one entry per cycle into the register file through Reg_Write/Write_Register/Write_Data.
- Optionally forwards pending (not yet written) data to the two read ports so consumers see the youngest value.

Parameters:
- WD, 32, data width in bits; matches the register file data width.
- SEL, 5, register address width; matches the register file select width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- wb_valid_i  input  1  upstream write request valid.
- wb_ready_o  output  1  queue can accept a request; equals !full.
- wb_addr_i  input  SEL  destination register of the request.
- wb_data_i  input  WD  data to write.
- wb_stall_i  input  1  holds the drain; no register file write while high.
- Reg_Write_o  output  1  register file write enable.
- Write_Register_o  output  SEL  register file write address (head entry).
- Write_Data_o  output  WD  register file write data (head entry).
- Read_Register_1_i  input  SEL  read address 1, also driven to the register file.
- Read_Register_2_i  input  SEL  read address 2.
- fwd_hit_1_o  output  1  read 1 matches a pending entry.
- fwd_hit_2_o  output  1  read 2 matches a pending entry.
- fwd_data_1_o  output  WD  youngest pending data for read 1.
- fwd_data_2_o  output  WD  youngest pending data for read 2.
- count_o  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage and pointers: circular FIFO with DEPTH entries of {addr, data}, a write pointer, a read pointer, and an occupancy counter of $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Reset (asynchronous, takes effect immediately): pointers and count go to 0.
  - Outputs while reset is asserted: Reg_Write_o=0, Write_Register_o=0, Write_Data_o=0, fwd_hit_*=0, fwd_data_*=0, count_o=0, wb_ready_o=1.
  - Entry contents do not need to be cleared.
  - Reset asserted mid-drain discards all pending writes; no partial write is issued.
- Push: occurs on an edge where wb_valid_i && wb_ready_o.
  - If wb_addr_i==0, the request is accepted but discarded; count and pointers do not change (register 0 is hardwired to zero).
  - Otherwise {wb_addr_i, wb_data_i} is written at the write pointer and the pointer increments.
- Drain:
  - Reg_Write_o = (count!=0) && !wb_stall_i, combinational.
  - Write_Register_o and Write_Data_o show the head entry, or 0 when empty.
  - On an edge where Reg_Write_o=1, the register file captures the write and the read pointer increments.
- Latency: a request pushed at edge N is driven on the write outputs in cycle N+1 and is written into the register file at edge N+1 if not stalled.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full: wb_ready_o=0. There is no pass-through, so a pop in the same cycle does not enable the push.
- Empty: Reg_Write_o=0 regardless of wb_stall_i.
- Ordering: strict FIFO. Multiple pending writes to the same register drain oldest first.
- Forwarding compare: each read address is compared against every valid entry. The youngest match (closest to the write pointer) wins. A read address of 0 never hits.
  - The head entry being written this cycle still counts as pending for forwarding.
  - Forwarding does not look at the incoming push in the same cycle.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined: the forwarding compare logic is built; fwd_hit_* and fwd_data_* behave as described in Behaviour.
- Not defined: no compare logic is built; fwd_hit_1_o, fwd_hit_2_o, fwd_data_1_o and fwd_data_2_o are tied to 0. Consumers must stall until count_o==0 to avoid stale reads.

Test Plan:
- Reset, then push addr=3 data=0xA5A5A5A5 with stall low -> next cycle Reg_Write_o=1, Write_Register_o=3, Write_Data_o=0xA5A5A5A5; count_o back to 0 after that edge.
- Stall high, push 4 entries (addr 1..4) -> count_o=4, wb_ready_o=0, a fifth push is not accepted. Release stall -> writes appear in order 1,2,3,4 on 4 consecutive cycles.
- Push addr=0 data=0xFFFFFFFF -> count_o stays 0 and Reg_Write_o stays 0.
- At full with stall low, hold valid -> each cycle one pop. The push is accepted only on the cycle after count drops to 3; ordering stays intact across the pointer wrap.
- (RF_WB_BYPASS_EN) With stall high, push addr=7 data=0x11 then addr=7 data=0x22; set Read_Register_1_i=7, Read_Register_2_i=0 -> fwd_hit_1_o=1, fwd_data_1_o=0x22, fwd_hit_2_o=0.
- Assert reset asynchronously (between edges) with 3 entries pending -> Reg_Write_o=0 and count_o=0 immediately. After release, no stale writes are issued.

Source files
------------

// File: rtl/rf_wb_queue.sv
// rf_wb_queue: write-back buffer in front of the register file write port.
// Requests are buffered in a circular FIFO of {addr, data}.
// The buffer drains one entry per cycle into the register file unless the drain is stalled.
// Optional feature macro: RF_WB_BYPASS_EN.
// When it is defined, pending entries are forwarded to the two read ports, and the youngest match wins.
// When it is undefined, the forwarding outputs are tied to zero.
module rf_wb_queue #(
    parameter int WD    = 32,
    parameter int SEL   = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_valid_i,
    output logic                     wb_ready_o,
    input  logic [SEL-1:0]           wb_addr_i,
    input  logic [WD-1:0]            wb_data_i,
    input  logic                     wb_stall_i,
    output logic                     Reg_Write_o,
    output logic [SEL-1:0]           Write_Register_o,
    output logic [WD-1:0]            Write_Data_o,
    input  logic [SEL-1:0]           Read_Register_1_i,
    input  logic [SEL-1:0]           Read_Register_2_i,
    output logic                     fwd_hit_1_o,
    output logic                     fwd_hit_2_o,
    output logic [WD-1:0]            fwd_data_1_o,
    output logic [WD-1:0]            fwd_data_2_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage. It is never cleared, because validity comes from count_q and the pointers.
    logic [SEL-1:0] addr_mem_q [DEPTH];
    logic [WD-1:0]  data_mem_q [DEPTH];

    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    logic           full;
    logic           empty;
    logic           push;
    logic           pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A pop never frees a slot for the push in the same cycle, because ready depends only on the current count.
    assign wb_ready_o = !full;

    // Writes to register 0 are handshaked but dropped, because x0 is hardwired to zero.
    assign push = wb_valid_i && !full && (wb_addr_i != '0);
    assign pop  = !empty && !wb_stall_i;

    assign Reg_Write_o      = pop;
    assign Write_Register_o = empty ? '0 : addr_mem_q[rd_ptr_q];
    assign Write_Data_o     = empty ? '0 : data_mem_q[rd_ptr_q];
    assign count_o          = count_q;

    // Next-state pointers and occupancy. Pointers wrap naturally at a power-of-two DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers. Reset discards every pending write immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Capture each accepted request at the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= wb_addr_i;
            data_mem_q[wr_ptr_q] <= wb_data_i;
        end
    end

`ifdef RF_WB_BYPASS_EN
    logic [SEL-1:0] rd_addr [2];
    logic           hit_vec [2];
    logic [WD-1:0]  hit_data [2];

    assign rd_addr[0] = Read_Register_1_i;
    assign rd_addr[1] = Read_Register_2_i;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic          hit;
        logic [WD-1:0] data;

        // Walk the pending entries from oldest to youngest so that a later match overrides an earlier one.
        always_comb begin
            logic [PW-1:0] slot;
            hit  = 1'b0;
            data = '0;
            slot = '0;
            for (int k = 0; k < DEPTH; k++) begin
                slot = rd_ptr_q + PW'(k);
                if ((CW'(k) < count_q) && (rd_addr[gi] != '0) &&
                    (addr_mem_q[slot] == rd_addr[gi])) begin
                    hit  = 1'b1;
                    data = data_mem_q[slot];
                end
            end
        end

        assign hit_vec[gi]  = hit;
        assign hit_data[gi] = data;
    end

    assign fwd_hit_1_o  = hit_vec[0];
    assign fwd_hit_2_o  = hit_vec[1];
    assign fwd_data_1_o = hit_data[0];
    assign fwd_data_2_o = hit_data[1];
`else
    // No forwarding is built. Consumers wait for count_o == 0 before they read.
    assign fwd_hit_1_o  = 1'b0;
    assign fwd_hit_2_o  = 1'b0;
    assign fwd_data_1_o = '0;
    assign fwd_data_2_o = '0;
`endif

endmodule
